bp_probe_gen: RTL and testbench
===============================

BP_PROBE_GEN -- requirements
Module: bp_probe_gen

Interface
REQ-001 SHALL have parameter N_PROBE, default 4, number of probe outputs (legal 1..8).
REQ-002 SHALL have parameter LFSR_SEED, default 16'hACE1, per-channel reset seed base.
REQ-003 SHALL have port i_clk, input, 1, sole clock; all flops rise-edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_cg, input, 1, clock gate; when 0 all state holds and no transfer completes.
REQ-006 SHALL have ports i_bp_data (input, 8), i_bp_valid (input, 1) and o_bp_ready (output, 1): the upstream BytePipe command stream.
REQ-007 SHALL have ports o_bp_data (output, 8), o_bp_valid (output, 1) and i_bp_ready (input, 1): the downstream BytePipe response stream.
REQ-008 SHALL have port o_probe, output, N_PROBE, registered stimulus pulses, one bit per channel.

Function
REQ-009 SHALL complete a transfer only on a cycle with i_cg=1, valid=1 and ready=1.
REQ-010 SHALL decode each command byte as {wr, addr[6:0]}; wr=1 means the next accepted byte is write data, wr=0 means a one-byte read response.
REQ-011 SHALL implement FSM states IDLE, GETDATA and RESPOND.
- IDLE: accept cmd; wr -> GETDATA; rd -> RESPOND.
- GETDATA: accept data, write register -> IDLE.
- RESPOND: o_bp_valid=1 and o_bp_data stable until accepted -> IDLE.
REQ-012 SHALL drive o_bp_ready=1 in IDLE and GETDATA and 0 in RESPOND, so there is no back-to-back read pipelining.
REQ-013 SHALL expose this register map; unused bits read 0 and bits at or above N_PROBE are ignored.
- 0x00 EN: RW, enable mask, reset 0x00.
- 0x01 MODE: RW; bit=1 periodic, 0 random; reset 0x00.
- 0x02 RESEED: WO, reads 0x00; a write reseeds every LFSR.
- 0x10+i, i<N_PROBE, PARAM_i: RW, reset 0x00.
- 0x7F ID: RO, returns N_PROBE.
- Other addresses: read 0x00, write ignored.
REQ-014 SHALL keep, per channel, a 16-bit Galois LFSR (taps mask 16'hB400, shift right) that advances every i_cg=1 cycle regardless of EN.
REQ-015 SHALL, in random mode, set o_probe[i] <= EN[i] & (lfsr_i[7:0] < PARAM_i): PARAM=0 never pulses, PARAM=255 gives density 255/256.
REQ-016 SHALL, in periodic mode, keep an 8-bit counter cnt_i that increments each i_cg=1 cycle; when cnt_i==PARAM_i, o_probe[i] <= EN[i] and cnt_i <= 0, giving period PARAM_i+1 (PARAM=0 means every cycle).
REQ-017 SHALL clear cnt_i on any write to MODE or PARAM_i, and while EN[i]=0.
REQ-018 SHALL, on a RESEED write with data d, load lfsr_i <= {d, 8'hA5 ^ (i+1)}, which is never zero.
REQ-019 SHALL apply a register write to the probe logic on the cycle after the data byte is accepted.
REQ-020 SHALL hold o_probe and the LFSRs while i_cg=0; o_probe is not forced low.
REQ-021 SHALL give the probe path 1-cycle latency from state to o_probe.

Reset
REQ-022 SHALL, while i_rst=1, asynchronously force: FSM=IDLE, o_bp_valid=0, o_bp_data=0x00, o_probe=0, EN=MODE=PARAM=0, cnt_i=0, lfsr_i={LFSR_SEED[15:8], LFSR_SEED[7:0] ^ (i+1)} (nonzero for i<8).
REQ-023 SHALL, if reset is asserted mid-command, discard any partial write or pending response.

Structure
REQ-024 SHALL place the register address constants, the FSM state enum and the LFSR taps constant in shared package bp_probe_gen_pkg.
REQ-025 SHALL implement one channel (LFSR, counter, compare, o_probe flop) as sub-module probe_chan, instantiated N_PROBE times via generate.

Verification
REQ-026 Read ID: send 0x7F -> one response byte 0x04; o_bp_ready=0 until it is accepted.
REQ-027 Periodic: write 0x10<-0x03, 0x01<-0x01, 0x00<-0x01 -> o_probe[0] pulses exactly every 4th i_cg cycle; other bits stay 0.
REQ-028 Random extremes: EN=0x0F, MODE=0, PARAM_0=0x00, PARAM_1=0xFF -> over 4096 cycles probe[0] has 0 pulses and probe[1] has at least 4000.
REQ-029 Reseed determinism: write RESEED<-0x5A twice, separated by 1000 cycles -> identical 256-cycle o_probe sequences after each reseed.
REQ-030 Backpressure and gating: hold i_bp_ready=0 for 20 cycles during a read of 0x10 -> o_bp_valid stays 1 with constant data; with i_cg=0 pulses, no transfer or probe change occurs.
REQ-031 Reset mid-write: assert i_rst after command 0x90 but before its data byte -> PARAM_0 reads back 0x00 and the FSM is in IDLE.

Source files
------------

// File: rtl/bp_probe_gen_pkg.sv
// rtl/bp_probe_gen_pkg.sv - shared constants, FSM states and LFSR step for the probe generator
package bp_probe_gen_pkg;

    localparam logic [6:0] ADDR_EN     = 7'h00;
    localparam logic [6:0] ADDR_MODE   = 7'h01;
    localparam logic [6:0] ADDR_RESEED = 7'h02;
    localparam logic [6:0] ADDR_PARAM  = 7'h10;
    localparam logic [6:0] ADDR_ID     = 7'h7F;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GETDATA = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // Galois form, shifting right: feedback taps are applied when bit 0 falls out
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/bp_probe_gen_probe_chan.sv
// rtl/bp_probe_gen_probe_chan.sv - one stimulus channel: LFSR, period counter, compare and output flop
module probe_chan
    import bp_probe_gen_pkg::*;
#(
    parameter logic [15:0] RST_SEED  = 16'hACE0,
    parameter logic [7:0]  RESEED_LO = 8'hA4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cg,
    input  logic       en,
    input  logic       periodic,
    input  logic [7:0] param,
    input  logic       clr,
    input  logic       reseed,
    input  logic [7:0] seed_hi,
    output logic       probe
);

    logic [15:0] lfsr;
    logic [7:0]  cnt;
    logic        hit;

    always_comb begin
        hit = periodic ? (cnt == param) : (lfsr[7:0] < param);
    end

    // The LFSR free-runs even when disabled so reseeded sequences stay reproducible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr  <= RST_SEED;
            cnt   <= 8'h00;
            probe <= 1'b0;
        end else if (cg) begin
            probe <= en & hit;
            lfsr  <= reseed ? {seed_hi, RESEED_LO} : lfsr_step(lfsr);
            if (clr || !en || (cnt == param)) begin
                cnt <= 8'h00;
            end else begin
                cnt <= cnt + 8'h01;
            end
        end
    end

endmodule

// File: rtl/bp_probe_gen.sv
// rtl/bp_probe_gen.sv - BytePipe-configured multi-channel random/periodic probe pulse generator
module bp_probe_gen
    import bp_probe_gen_pkg::*;
#(
    parameter int          N_PROBE   = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cg,
    input  logic [7:0]         i_bp_data,
    input  logic               i_bp_valid,
    output logic               o_bp_ready,
    output logic [7:0]         o_bp_data,
    output logic               o_bp_valid,
    input  logic               i_bp_ready,
    output logic [N_PROBE-1:0] o_probe
);

    state_t             state;
    state_t             state_nx;
    logic [6:0]         addr_q;
    logic [N_PROBE-1:0] en_q;
    logic [N_PROBE-1:0] mode_q;
    logic [7:0]         param_q [N_PROBE];
    logic               cmd_acc;
    logic               data_acc;
    logic [7:0]         rd_val;
    logic               reseed;
    logic [N_PROBE-1:0] clr_v;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Every transfer is qualified by i_cg, so a gated cycle never moves the FSM
    always_comb begin
        state_nx   = state;
        o_bp_ready = 1'b0;
        o_bp_valid = 1'b0;
        cmd_acc    = 1'b0;
        data_acc   = 1'b0;
        case (state)
            ST_IDLE: begin
                o_bp_ready = 1'b1;
                if (i_cg && i_bp_valid) begin
                    cmd_acc  = 1'b1;
                    state_nx = i_bp_data[7] ? ST_GETDATA : ST_RESPOND;
                end
            end
            ST_GETDATA: begin
                o_bp_ready = 1'b1;
                if (i_cg && i_bp_valid) begin
                    data_acc = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_RESPOND: begin
                o_bp_valid = 1'b1;
                if (i_cg && i_bp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Read value is looked up from the command byte itself and frozen into o_bp_data
    always_comb begin
        rd_val = 8'h00;
        if (i_bp_data[6:0] == ADDR_EN) begin
            rd_val = 8'(en_q);
        end else if (i_bp_data[6:0] == ADDR_MODE) begin
            rd_val = 8'(mode_q);
        end else if (i_bp_data[6:0] == ADDR_ID) begin
            rd_val = 8'(N_PROBE);
        end
        for (int i = 0; i < N_PROBE; i++) begin
            if (i_bp_data[6:0] == ADDR_PARAM + 7'(i)) begin
                rd_val = param_q[i];
            end
        end
    end

    always_comb begin
        reseed = data_acc && (addr_q == ADDR_RESEED);
        for (int i = 0; i < N_PROBE; i++) begin
            clr_v[i] = data_acc && ((addr_q == ADDR_MODE) || (addr_q == ADDR_PARAM + 7'(i)));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q    <= 7'h00;
            o_bp_data <= 8'h00;
            en_q      <= '0;
            mode_q    <= '0;
            for (int i = 0; i < N_PROBE; i++) begin
                param_q[i] <= 8'h00;
            end
        end else begin
            if (cmd_acc) begin
                addr_q <= i_bp_data[6:0];
                if (!i_bp_data[7]) begin
                    o_bp_data <= rd_val;
                end
            end
            if (data_acc) begin
                if (addr_q == ADDR_EN) begin
                    en_q <= i_bp_data[N_PROBE-1:0];
                end
                if (addr_q == ADDR_MODE) begin
                    mode_q <= i_bp_data[N_PROBE-1:0];
                end
                for (int i = 0; i < N_PROBE; i++) begin
                    if (addr_q == ADDR_PARAM + 7'(i)) begin
                        param_q[i] <= i_bp_data;
                    end
                end
            end
        end
    end

    // Channel i is seeded with its index folded into the low byte so no two channels match
    for (genvar g = 0; g < N_PROBE; g++) begin : g_chan
        probe_chan #(
            .RST_SEED  ({LFSR_SEED[15:8], LFSR_SEED[7:0] ^ 8'(g + 1)}),
            .RESEED_LO (8'hA5 ^ 8'(g + 1))
        ) u_chan (
            .clk      (i_clk),
            .rst      (i_rst),
            .cg       (i_cg),
            .en       (en_q[g]),
            .periodic (mode_q[g]),
            .param    (param_q[g]),
            .clr      (clr_v[g]),
            .reseed   (reseed),
            .seed_hi  (i_bp_data),
            .probe    (o_probe[g])
        );
    end

endmodule

// File: tb/tb_bp_probe_gen.sv
// tb/tb_bp_probe_gen.sv - self-checking bench for bp_probe_gen with a behavioural reference model
module tb_bp_probe_gen;

    localparam int NP = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_cg = 1'b1;
    logic [7:0]    i_bp_data = 8'h00;
    logic          i_bp_valid = 1'b0;
    logic          o_bp_ready;
    logic [7:0]    o_bp_data;
    logic          o_bp_valid;
    logic          i_bp_ready = 1'b0;
    logic [NP-1:0] o_probe;

    int n_cmp = 0;
    int n_bad = 0;
    bit cg_rand = 1'b0;

    bp_probe_gen #(.N_PROBE(NP), .LFSR_SEED(16'hACE1)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_cg       (i_cg),
        .i_bp_data  (i_bp_data),
        .i_bp_valid (i_bp_valid),
        .o_bp_ready (o_bp_ready),
        .o_bp_data  (o_bp_data),
        .o_bp_valid (o_bp_valid),
        .i_bp_ready (i_bp_ready),
        .o_probe    (o_probe)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file, protocol phase, per-channel LFSR and age since restart
    int       m_en, m_mode, m_phase, m_addr, m_resp;
    int       m_param [NP];
    int       m_lfsr  [NP];
    int       m_age   [NP];
    logic [7:0] exp_probe;

    function automatic int model_read(input int a);
        if (a == 0) return m_en;
        if (a == 1) return m_mode;
        if (a == 127) return NP;
        if (a >= 16 && a < 16 + NP) return m_param[a - 16];
        return 0;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin : model
        int wa;
        int wd;
        bit en_i;
        bit per_i;
        bit clr_i;
        if (i_rst) begin
            m_en = 0; m_mode = 0; m_phase = 0; m_addr = 0; m_resp = 0;
            exp_probe = 8'h00;
            for (int i = 0; i < NP; i++) begin
                m_param[i] = 0;
                m_age[i] = 0;
                m_lfsr[i] = (8'hAC << 8) | (8'hE1 ^ (i + 1));
            end
        end else if (i_cg) begin
            wa = -1;
            wd = 0;
            if (m_phase == 0) begin
                if (i_bp_valid) begin
                    m_addr = i_bp_data & 127;
                    if (i_bp_data[7]) m_phase = 1;
                    else begin
                        m_phase = 2;
                        m_resp = model_read(m_addr);
                    end
                end
            end else if (m_phase == 1) begin
                if (i_bp_valid) begin
                    wa = m_addr;
                    wd = i_bp_data;
                    m_phase = 0;
                end
            end else if (i_bp_ready) begin
                m_phase = 0;
            end
            for (int i = 0; i < NP; i++) begin
                en_i = ((m_en >> i) & 1) == 1;
                per_i = ((m_mode >> i) & 1) == 1;
                if (per_i) exp_probe[i] = en_i && ((m_age[i] % (m_param[i] + 1)) == m_param[i]);
                else exp_probe[i] = en_i && ((m_lfsr[i] & 255) < m_param[i]);
                clr_i = (wa == 1) || (wa == 16 + i);
                m_age[i] = (clr_i || !en_i) ? 0 : m_age[i] + 1;
                if (wa == 2) m_lfsr[i] = (wd << 8) | (8'hA5 ^ (i + 1));
                else m_lfsr[i] = (m_lfsr[i] >> 1) ^ (((m_lfsr[i] & 1) != 0) ? 'hB400 : 0);
            end
            if (wa == 0) m_en = wd & ((1 << NP) - 1);
            if (wa == 1) m_mode = wd & ((1 << NP) - 1);
            if (wa >= 16 && wa < 16 + NP) m_param[wa - 16] = wd;
        end
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            chk("model_probe", 32'(o_probe), 32'(exp_probe[NP-1:0]));
            chk("model_ready", 32'(o_bp_ready), 32'(m_phase != 2));
            chk("model_valid", 32'(o_bp_valid), 32'(m_phase == 2));
            if (m_phase == 2) chk("model_rdata", 32'(o_bp_data), 32'(m_resp));
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (cg_rand) i_cg = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_bp_valid = 1'b0;
        i_bp_ready = 1'b0;
        i_cg = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        bit done;
        done = 1'b0;
        i_bp_data = b;
        i_bp_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            acc = i_cg && o_bp_ready;
            tick();
            done = acc;
        end
        i_bp_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic recv_byte(output logic [7:0] d, input int hold);
        bit acc;
        bit done;
        done = 1'b0;
        d = 8'h00;
        i_bp_ready = 1'b0;
        repeat (hold) tick();
        i_bp_ready = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            acc = i_cg && o_bp_valid;
            d = o_bp_data;
            tick();
            done = acc;
        end
        i_bp_ready = 1'b0;
        if (!done) chk("recv_timeout", 32'd1, 32'd0);
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
        send_byte({1'b1, a});
        send_byte(d);
    endtask

    task automatic read_reg(input logic [6:0] a, output logic [7:0] d, input int hold);
        send_byte({1'b0, a});
        recv_byte(d, hold);
    endtask

    typedef struct {
        bit         wr;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [12];
    logic [NP-1:0] seq_a [256];
    logic [NP-1:0] seq_b [256];
    logic [6:0] addr_pool [10];

    initial begin : main
        logic [7:0] rd;
        int c0, c1, other, last, badgap, diffs, ones;
        logic [NP-1:0] p;
        bit bad_v, bad_d, bad_p;

        vecs[0]  = '{1'b0, 7'h7F, 8'h00, 8'h04};
        vecs[1]  = '{1'b1, 7'h00, 8'hFF, 8'h0F};
        vecs[2]  = '{1'b1, 7'h01, 8'hA5, 8'h05};
        vecs[3]  = '{1'b1, 7'h02, 8'h33, 8'h00};
        vecs[4]  = '{1'b1, 7'h13, 8'h77, 8'h77};
        vecs[5]  = '{1'b1, 7'h10, 8'hC8, 8'hC8};
        vecs[6]  = '{1'b1, 7'h14, 8'h55, 8'h00};
        vecs[7]  = '{1'b1, 7'h40, 8'h12, 8'h00};
        vecs[8]  = '{1'b1, 7'h7F, 8'h99, 8'h04};
        vecs[9]  = '{1'b0, 7'h13, 8'h00, 8'h77};
        vecs[10] = '{1'b1, 7'h00, 8'h00, 8'h00};
        vecs[11] = '{1'b1, 7'h01, 8'h00, 8'h00};
        addr_pool = '{7'h00, 7'h01, 7'h02, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h7F, 7'h05};

        do_reset();
        chk("rst_probe", 32'(o_probe), 32'd0);
        chk("rst_valid", 32'(o_bp_valid), 32'd0);
        chk("rst_data", 32'(o_bp_data), 32'd0);
        chk("rst_ready", 32'(o_bp_ready), 32'd1);

        // ID read: response held and command path closed until it is taken
        send_byte(8'h7F);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("id_ready_low", 32'(o_bp_ready), 32'd0);
        end
        recv_byte(rd, 0);
        chk("id_value", 32'(rd), 32'h04);

        for (int v = 0; v < 12; v++) begin
            if (vecs[v].wr) write_reg(vecs[v].addr, vecs[v].wdata);
            read_reg(vecs[v].addr, rd, v % 3);
            chk($sformatf("vec%0d_read", v), 32'(rd), 32'(vecs[v].exp));
        end

        // Periodic: PARAM_0=3 must give one pulse every 4 cycles
        do_reset();
        write_reg(7'h10, 8'h03);
        write_reg(7'h01, 8'h01);
        write_reg(7'h00, 8'h01);
        tick();
        tick();
        c0 = 0; other = 0; last = -1; badgap = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (o_probe[0]) begin
                if (last >= 0 && k - last != 4) badgap++;
                last = k;
                c0++;
            end
            if (o_probe[NP-1:1] != 0) other++;
        end
        chk("per_count", 32'(c0), 32'd10);
        chk("per_gap", 32'(badgap), 32'd0);
        chk("per_other", 32'(other), 32'd0);

        // Random density extremes
        do_reset();
        write_reg(7'h00, 8'h0F);
        write_reg(7'h01, 8'h00);
        write_reg(7'h10, 8'h00);
        write_reg(7'h11, 8'hFF);
        tick();
        c0 = 0; c1 = 0;
        for (int k = 0; k < 4096; k++) begin
            tick();
            c0 += int'(o_probe[0]);
            c1 += int'(o_probe[1]);
        end
        chk("rnd_zero", 32'(c0), 32'd0);
        chk("rnd_dense", 32'(c1 >= 4000), 32'd1);

        // Reseed determinism
        write_reg(7'h12, 8'h80);
        write_reg(7'h13, 8'h40);
        write_reg(7'h02, 8'h5A);
        for (int k = 0; k < 256; k++) begin
            tick();
            seq_a[k] = o_probe;
        end
        repeat (1000) tick();
        write_reg(7'h02, 8'h5A);
        diffs = 0; ones = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            seq_b[k] = o_probe;
            if (seq_b[k] !== seq_a[k]) diffs++;
            ones += int'(seq_a[k][2]);
        end
        chk("reseed_same", 32'(diffs), 32'd0);
        chk("reseed_active", 32'(ones > 0), 32'd1);

        // Backpressure then clock gating with a pending response
        do_reset();
        write_reg(7'h10, 8'h3C);
        write_reg(7'h11, 8'h01);
        write_reg(7'h01, 8'h03);
        write_reg(7'h00, 8'h03);
        send_byte(8'h10);
        bad_v = 1'b0; bad_d = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_bp_valid !== 1'b1) bad_v = 1'b1;
            if (o_bp_data !== 8'h3C) bad_d = 1'b1;
        end
        chk("bp_hold_valid", 32'(bad_v), 32'd0);
        chk("bp_hold_data", 32'(bad_d), 32'd0);
        i_bp_ready = 1'b1;
        i_cg = 1'b0;
        p = o_probe;
        bad_v = 1'b0; bad_p = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_bp_valid !== 1'b1 || o_bp_data !== 8'h3C) bad_v = 1'b1;
            if (o_probe !== p) bad_p = 1'b1;
        end
        chk("cg_no_xfer", 32'(bad_v), 32'd0);
        chk("cg_probe_hold", 32'(bad_p), 32'd0);
        i_cg = 1'b1;
        recv_byte(rd, 0);
        chk("bp_value", 32'(rd), 32'h3C);

        // Reset between a write command and its data byte
        do_reset();
        send_byte(8'h90);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        tick();
        chk("midrst_idle", 32'(o_bp_ready), 32'd1);
        chk("midrst_novalid", 32'(o_bp_valid), 32'd0);
        read_reg(7'h10, rd, 0);
        chk("midrst_param0", 32'(rd), 32'h00);

        // Randomized traffic with random gating, checked against the model every cycle
        do_reset();
        cg_rand = 1'b1;
        for (int op = 0; op < 300; op++) begin
            int r;
            logic [6:0] a;
            r = $urandom_range(0, 9);
            a = addr_pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) a = 7'($urandom);
            if (r <= 3) write_reg(a, 8'($urandom));
            else if (r <= 6) read_reg(a, rd, $urandom_range(0, 4));
            else repeat ($urandom_range(1, 20)) tick();
        end
        cg_rand = 1'b0;
        i_cg = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
